uart_rx_core: RTL and testbench

//   Standalone UART receive engine: the serial-in counterpart of the UART transmit path.

---
 rtl/uart_rx_core.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Function : 16x-oversampled UART receiver (2-FF rx synchronizer, selectable
//            baud, frame/parity status, 1-cycle done strobe).
// Options  : define UART_RX_PARITY_EN to add one even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int SYSTEM_CLK_f = 100000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           B_rate,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int c_DIV_4800  = SYSTEM_CLK_f / (4800 * 16);
  localparam int c_DIV_9600  = SYSTEM_CLK_f / (9600 * 16);
  localparam int c_DIV_19200 = SYSTEM_CLK_f / (19200 * 16);
  localparam int c_DIV_38400 = SYSTEM_CLK_f / (38400 * 16);
  localparam int c_DIV_W     = $clog2(c_DIV_4800 + 1);
  localparam int c_N_W       = $clog2(DATA_BITS + 1);

  localparam logic [c_N_W-1:0] c_LAST_DATA = c_N_W'(DATA_BITS - 1);
  localparam logic [c_N_W-1:0] c_LAST_STOP = c_N_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_DIV_W-1:0]   r_div;
  logic [c_DIV_W-1:0]   w_div_sel;
  logic [c_DIV_W-1:0]   r_tick_cnt;
  logic [3:0]           r_s_cnt;
  logic [c_N_W-1:0]     r_n;
  logic [DATA_BITS-1:0] r_sr;
  logic                 r_ferr_pend;
  logic                 r_wait_high;
  logic                 w_s_tick;
  logic                 w_bit_end;
  logic                 w_start_det;
  logic                 w_frame_done;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_comb begin
    w_div_sel = c_DIV_W'(c_DIV_4800);
    case (B_rate)
      2'b01:   w_div_sel = c_DIV_W'(c_DIV_9600);
      2'b10:   w_div_sel = c_DIV_W'(c_DIV_19200);
      2'b11:   w_div_sel = c_DIV_W'(c_DIV_38400);
      default: w_div_sel = c_DIV_W'(c_DIV_4800);
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_det) w_state_nxt = S_START;
      S_START: if (w_s_tick && (r_s_cnt == 4'd7))
                 w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_end && (r_n == c_LAST_DATA))
`ifdef UART_RX_PARITY_EN
                 w_state_nxt = S_PARITY;
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`else
                 w_state_nxt = S_STOP;
`endif
      S_STOP:  if (w_frame_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs and decoded events
  always_comb begin
    rx_busy      = (r_state != S_IDLE);
    w_s_tick     = (r_tick_cnt == (r_div - c_DIV_W'(1)));
    w_bit_end    = w_s_tick && (r_s_cnt == 4'd15);
    // After a break the line must go high before a new start is accepted.
    w_start_det  = (r_state == S_IDLE) && !r_rx_sync && !r_wait_high;
    w_frame_done = (r_state == S_STOP) && w_bit_end && (r_n == c_LAST_STOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div        <= '0;
      r_tick_cnt   <= '0;
      r_s_cnt      <= '0;
      r_n          <= '0;
      r_sr         <= '0;
      r_ferr_pend  <= 1'b0;
      r_wait_high  <= 1'b0;
      rx_dout      <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= w_frame_done;
      r_wait_high  <= !r_rx_sync && (r_wait_high || w_frame_done);

      // Tick counter parks at zero in IDLE so each frame starts phase-aligned.
      if (r_state == S_IDLE) begin
        r_div      <= w_div_sel;
        r_tick_cnt <= '0;
      end else if (w_s_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + c_DIV_W'(1);
      end

      if (w_start_det) begin
        r_s_cnt     <= '0;
        r_ferr_pend <= 1'b0;
      end else if (w_s_tick) begin
        case (r_state)
          S_START: begin
            if (r_s_cnt == 4'd7) begin
              r_s_cnt <= '0;
              r_n     <= '0;
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
          S_DATA: begin
            r_s_cnt <= r_s_cnt + 4'd1;
            if (r_s_cnt == 4'd15) begin
              r_sr <= {r_rx_sync, r_sr[DATA_BITS-1:1]};
              r_n  <= (r_n == c_LAST_DATA) ? '0 : r_n + c_N_W'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: r_s_cnt <= r_s_cnt + 4'd1;
`endif
          S_STOP: begin
            r_s_cnt <= r_s_cnt + 4'd1;
            if (r_s_cnt == 4'd15) begin
              if (!r_rx_sync) r_ferr_pend <= 1'b1;
              r_n <= r_n + c_N_W'(1);
            end
          end
          default: r_s_cnt <= '0;
        endcase
      end

      if (w_frame_done) begin
        rx_dout   <= r_sr;
        frame_err <= r_ferr_pend || !r_rx_sync;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_bit  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_bit_end) r_par_bit <= r_rx_sync;
      if (w_frame_done) parity_err <= (^r_sr) != r_par_bit;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Function : directed self-checking bench for uart_rx_core (2 MHz clock model:
//            divisors 26/13/6/3, bit periods 416/208/96/48 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int c_CLK_HZ = 2000000;
  localparam int c_B00    = 416;
  localparam int c_B01    = 208;
  localparam int c_B11    = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] B_rate = 2'b11;
  logic       rx = 1'b1;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_strobes = 0;
  int         n_ferr    = 0;
  int         n_busy    = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_b[32];

  uart_rx_core #(
    .DATA_BITS(8),
    .STOP_BITS(1),
    .SYSTEM_CLK_f(c_CLK_HZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .B_rate(B_rate),
    .rx(rx),
    .rx_dout(rx_dout),
    .rx_done_tick(rx_done_tick),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_busy) n_busy++;
    if (rx_done_tick) begin
      n_strobes++;
      rx_q.push_back(rx_dout);
      if (frame_err) n_ferr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int bclk);
    rx = v;
    repeat (bclk) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d, bclk);
`endif
    drive_bit(stop_val, bclk);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic pbit, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    drive_bit(pbit, bclk);
    drive_bit(1'b1, bclk);
  endtask
`endif

  initial begin
    int s0;
    int f0;
    int b0;
    int qb;

    // Reset state
    settle(3);
    check("rst_dout", 32'(rx_dout), 32'h0);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b1;
    settle(5);

    // Clean frame 0xA5 at 38400
    s0 = n_strobes;
    send_frame(8'hA5, 1'b1, c_B11);
    settle(c_B11);
    check("a5_strobes", 32'(n_strobes - s0), 32'd1);
    check("a5_dout", 32'(rx_dout), 32'hA5);
    check("a5_ferr", 32'(frame_err), 32'h0);
    check("a5_perr", 32'(parity_err), 32'h0);
    check("a5_busy", 32'(rx_busy), 32'h0);

    // Short low pulse rejected at start-bit centre
    s0 = n_strobes;
    b0 = n_busy;
    rx = 1'b0;
    repeat (16) @(posedge clk);
    rx = 1'b1;
    settle(100);
    check("glitch_strobes", 32'(n_strobes - s0), 32'd0);
    check("glitch_busy_seen", 32'(n_busy > b0), 32'd1);
    check("glitch_busy_end", 32'(rx_busy), 32'h0);
    check("glitch_dout_hold", 32'(rx_dout), 32'hA5);

    // Framing error still delivers the byte; next clean frame clears it
    s0 = n_strobes;
    send_frame(8'h3C, 1'b0, c_B11);
    settle(c_B11);
    check("ferr_strobes", 32'(n_strobes - s0), 32'd1);
    check("ferr_dout", 32'(rx_dout), 32'h3C);
    check("ferr_flag", 32'(frame_err), 32'h1);
    send_frame(8'h00, 1'b1, c_B11);
    settle(c_B11);
    check("ferr_clr_dout", 32'(rx_dout), 32'h00);
    check("ferr_clr_flag", 32'(frame_err), 32'h0);

    // 32 random bytes back-to-back
    s0 = n_strobes;
    f0 = n_ferr;
    qb = rx_q.size();
    for (int i = 0; i < 32; i++) begin
      exp_b[i] = 8'($urandom);
      send_frame(exp_b[i], 1'b1, c_B11);
    end
    settle(c_B11);
    check("b2b_strobes", 32'(n_strobes - s0), 32'd32);
    check("b2b_ferr", 32'(n_ferr - f0), 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (qb + i < rx_q.size()) check($sformatf("b2b_byte%0d", i), 32'(rx_q[qb+i]), 32'(exp_b[i]));
      else check($sformatf("b2b_missing%0d", i), 32'(rx_q.size()), 32'(qb + 32));
    end

    // Baud change mid-frame only applies from the next frame
    s0 = n_strobes;
    fork
      send_frame(8'hC3, 1'b1, c_B11);
      begin
        repeat (100) @(posedge clk);
        B_rate = 2'b00;
      end
    join
    settle(c_B11);
    check("bchg_strobes", 32'(n_strobes - s0), 32'd1);
    check("bchg_dout", 32'(rx_dout), 32'hC3);

    // 9600 baud
    B_rate = 2'b01;
    settle(4);
    send_frame(8'h96, 1'b1, c_B01);
    settle(c_B01);
    check("r9600_dout", 32'(rx_dout), 32'h96);
    check("r9600_ferr", 32'(frame_err), 32'h0);

    // Reset in the middle of data bit 4 at 4800 abandons the frame
    B_rate = 2'b00;
    settle(4);
    s0 = n_strobes;
    drive_bit(1'b0, c_B00);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i), c_B00);
    rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(rx_busy), 32'h0);
    check("arst_dout", 32'(rx_dout), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    settle(c_B00);
    check("arst_strobes", 32'(n_strobes - s0), 32'd0);
    check("arst_idle", 32'(rx_busy), 32'h0);
    send_frame(8'h5A, 1'b1, c_B00);
    settle(c_B00);
    check("resend_strobes", 32'(n_strobes - s0), 32'd1);
    check("resend_dout", 32'(rx_dout), 32'h5A);

    // Break: one errored all-zero frame, no re-arm until the line goes high
    B_rate = 2'b11;
    settle(4);
    s0 = n_strobes;
    rx = 1'b0;
    settle(c_B11 * 12);
    check("brk_strobes", 32'(n_strobes - s0), 32'd1);
    check("brk_dout", 32'(rx_dout), 32'h00);
    check("brk_ferr", 32'(frame_err), 32'h1);
    check("brk_busy", 32'(rx_busy), 32'h0);
    settle(c_B11 * 4);
    check("brk_hold_strobes", 32'(n_strobes - s0), 32'd1);
    check("brk_hold_busy", 32'(rx_busy), 32'h0);
    rx = 1'b1;
    settle(c_B11);
    send_frame(8'h81, 1'b1, c_B11);
    settle(c_B11);
    check("brk_rearm_dout", 32'(rx_dout), 32'h81);
    check("brk_rearm_ferr", 32'(frame_err), 32'h0);

`ifdef UART_RX_PARITY_EN
    send_frame_par(8'h03, 1'b1, c_B11);
    settle(c_B11);
    check("par_bad_dout", 32'(rx_dout), 32'h03);
    check("par_bad_flag", 32'(parity_err), 32'h1);
    send_frame_par(8'h03, 1'b0, c_B11);
    settle(c_B11);
    check("par_ok_flag", 32'(parity_err), 32'h0);
`else
    check("par_tied_low", 32'(parity_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
